// File: rtl/blit_pkg.sv
// Shared types and constants for the blit scheduler.
// Screen geometry, default colour key and packed-field helpers.
package blit_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FIN
   } state_e;

   localparam logic [8:0] SCREEN_W = 9'd160;
   localparam logic [8:0] SCREEN_H = 9'd120;

   localparam logic [11:0] KEY_COLOUR_DEF = 12'h0AE;

   localparam int FIELD_W = 8;

   function automatic int field_lo(input int idx);
      return idx * FIELD_W;
   endfunction

endpackage

// File: rtl/blit_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from last-granted+1.
// Pointer advances only when enabled and a request wins.
module rr_arbiter #(
   parameter int NREQ = 3,
   parameter int IW   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            en,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx,
   output logic            any
);

   logic [IW-1:0] ptr_q, ptr_d;
   int j;
   int k;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      ptr_d   = ptr_q;
      j       = 0;
      k       = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = int'(ptr_q) + i;
         if (j >= NREQ) j = j - NREQ;
         if (!any && req[j]) begin
            any     = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = IW'(j);
         end
      end
      if (en && any) begin
         k = int'(gnt_idx) + 1;
         if (k >= NREQ) k = 0;
         ptr_d = IW'(k);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/blit_scheduler.sv
// Shares the vga_adapter pixel port between ROM blit requesters.
// Row-major ROM walk, one-cycle ROM alignment, colour key, clipping.
module blit_scheduler
   import blit_pkg::*;
#(
   parameter int              NREQ       = 3,
   parameter int              AW         = 15,
   parameter int              CW         = 12,
   parameter logic [CW-1:0]   KEY_COLOUR = KEY_COLOUR_DEF
) (
   input  logic                CLOCK_50,
   input  logic                resetn,
   input  logic [NREQ-1:0]     req,
   input  logic [8*NREQ-1:0]   req_x0,
   input  logic [8*NREQ-1:0]   req_y0,
   input  logic [8*NREQ-1:0]   req_w,
   input  logic [8*NREQ-1:0]   req_h,
   input  logic [NREQ-1:0]     req_key,
   output logic [NREQ-1:0]     grant,
   output logic [NREQ-1:0]     done,
   output logic [AW-1:0]       rom_addr,
   output logic [1:0]          rom_sel,
   input  logic [CW-1:0]       rom_q,
   output logic [7:0]          x,
   output logic [7:0]          y,
   output logic [CW-1:0]       colour,
   output logic                plot,
   output logic                busy
);

   state_e state_q, state_d;

   logic [NREQ-1:0] grant_q, grant_d;
   logic [1:0]      sel_q, sel_d;
   logic [7:0]      x0_q, x0_d;
   logic [7:0]      y0_q, y0_d;
   logic [7:0]      w_q, w_d;
   logic [7:0]      h_q, h_d;
   logic            key_q, key_d;
   logic [7:0]      col_q, col_d;
   logic [7:0]      row_q, row_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            drain_q, drain_d;

   logic            v1_q, v1_d;
   logic [8:0]      x1_q, x1_d;
   logic [8:0]      y1_q, y1_d;

   logic [7:0]      x_q, x_d;
   logic [7:0]      y_q, y_d;
   logic [CW-1:0]   colour_q, colour_d;
   logic            plot_q, plot_d;

   logic [NREQ-1:0] arb_gnt;
   logic [1:0]      arb_idx;
   logic            arb_any;
   logic            arb_en;
   int              lo;

   assign arb_en = (state_q == IDLE);

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (2)
   ) u_arb (
      .clk     (CLOCK_50),
      .rst_n   (resetn),
      .req     (req),
      .en      (arb_en),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      sel_d   = sel_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      w_d     = w_q;
      h_d     = h_q;
      key_d   = key_q;
      col_d   = col_q;
      row_d   = row_q;
      addr_d  = addr_q;
      drain_d = drain_q;
      v1_d    = 1'b0;
      x1_d    = x1_q;
      y1_d    = y1_q;
      lo      = field_lo(int'(arb_idx));

      unique case (state_q)
         IDLE: begin
            if (arb_any) begin
               grant_d = arb_gnt;
               sel_d   = arb_idx;
               x0_d    = req_x0[lo +: FIELD_W];
               y0_d    = req_y0[lo +: FIELD_W];
               w_d     = req_w[lo +: FIELD_W];
               h_d     = req_h[lo +: FIELD_W];
               key_d   = req_key[arb_idx];
               col_d   = '0;
               row_d   = '0;
               addr_d  = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            // Empty rectangles skip straight to completion.
            if (w_q == 8'd0 || h_q == 8'd0) begin
               state_d = FIN;
            end else begin
               v1_d   = 1'b1;
               x1_d   = {1'b0, x0_q} + {1'b0, col_q};
               y1_d   = {1'b0, y0_q} + {1'b0, row_q};
               addr_d = addr_q + 1'b1;
               if (col_q == w_q - 8'd1) begin
                  col_d = '0;
                  if (row_q == h_q - 8'd1) begin
                     drain_d = 1'b0;
                     state_d = DRAIN;
                  end else begin
                     row_d = row_q + 8'd1;
                  end
               end else begin
                  col_d = col_q + 8'd1;
               end
            end
         end
         DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) state_d = FIN;
         end
         FIN: begin
            grant_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   // Output stage: rom_q lines up with the stage-1 coordinate.
   always_comb begin
      x_d      = x_q;
      y_d      = y_q;
      colour_d = colour_q;
      plot_d   = v1_q
               && !(key_q && rom_q == KEY_COLOUR)
               && (x1_q < SCREEN_W)
               && (y1_q < SCREEN_H);
      if (plot_d) begin
         x_d      = x1_q[7:0];
         y_d      = y1_q[7:0];
         colour_d = rom_q;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         sel_q    <= '0;
         x0_q     <= '0;
         y0_q     <= '0;
         w_q      <= '0;
         h_q      <= '0;
         key_q    <= 1'b0;
         col_q    <= '0;
         row_q    <= '0;
         addr_q   <= '0;
         drain_q  <= 1'b0;
         v1_q     <= 1'b0;
         x1_q     <= '0;
         y1_q     <= '0;
         x_q      <= '0;
         y_q      <= '0;
         colour_q <= '0;
         plot_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         sel_q    <= sel_d;
         x0_q     <= x0_d;
         y0_q     <= y0_d;
         w_q      <= w_d;
         h_q      <= h_d;
         key_q    <= key_d;
         col_q    <= col_d;
         row_q    <= row_d;
         addr_q   <= addr_d;
         drain_q  <= drain_d;
         v1_q     <= v1_d;
         x1_q     <= x1_d;
         y1_q     <= y1_d;
         x_q      <= x_d;
         y_q      <= y_d;
         colour_q <= colour_d;
         plot_q   <= plot_d;
      end
   end

   assign grant    = grant_q;
   assign done     = (state_q == FIN) ? grant_q : '0;
   assign rom_addr = addr_q;
   assign rom_sel  = sel_q;
   assign x        = x_q;
   assign y        = y_q;
   assign colour   = colour_q;
   assign plot     = plot_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_blit_scheduler.sv
// Directed bench for blit_scheduler with a one-cycle ROM model.
// Inputs change and outputs are sampled on the falling edge.
module tb_blit_scheduler;

   logic          clk = 1'b0;
   logic          resetn;
   logic [2:0]    req;
   logic [23:0]   req_x0, req_y0, req_w, req_h;
   logic [2:0]    req_key;
   logic [2:0]    grant, done;
   logic [14:0]   rom_addr;
   logic [1:0]    rom_sel;
   logic [11:0]   rom_q;
   logic [7:0]    x, y;
   logic [11:0]   colour;
   logic          plot, busy;

   int rom_mode = 0;
   int checks = 0;
   int errors = 0;

   blit_scheduler dut (
      .CLOCK_50 (clk),
      .resetn   (resetn),
      .req      (req),
      .req_x0   (req_x0),
      .req_y0   (req_y0),
      .req_w    (req_w),
      .req_h    (req_h),
      .req_key  (req_key),
      .grant    (grant),
      .done     (done),
      .rom_addr (rom_addr),
      .rom_sel  (rom_sel),
      .rom_q    (rom_q),
      .x        (x),
      .y        (y),
      .colour   (colour),
      .plot     (plot),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] rom_data(input logic [14:0] a);
      if (rom_mode == 0) return 12'(a + 15'd1);
      case (a[1:0])
         2'd0:    return 12'h0AE;
         2'd1:    return 12'hFFF;
         2'd2:    return 12'h0AE;
         default: return 12'h123;
      endcase
   endfunction

   always @(posedge clk) rom_q <= rom_data(rom_addr);

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic start(input int i, input logic [7:0] x0, y0, w, h,
                        input logic key);
      req_x0[8*i +: 8] = x0;
      req_y0[8*i +: 8] = y0;
      req_w[8*i +: 8]  = w;
      req_h[8*i +: 8]  = h;
      req_key[i]       = key;
      req[i]           = 1'b1;
      @(negedge clk);
   endtask

   logic [2:0] seq [4];
   int         gaps [3];
   int         ng, zrun, multi;
   logic [2:0] prevg;

   initial begin
      resetn = 1'b0;
      req = '0; req_x0 = '0; req_y0 = '0;
      req_w = '0; req_h = '0; req_key = '0;
      repeat (2) cyc();
      chk("reset_outputs",
          {grant, done, rom_addr, rom_sel, x, y, colour, plot, busy}, 0);
      resetn = 1'b1;
      cyc();

      // single 2x2 blit, ROM returns addr+1
      start(0, 8'd10, 8'd20, 8'd2, 8'd2, 1'b0);
      chk("t1_grant", grant, 3'b001);
      chk("t1_addr0", rom_addr, 0);
      chk("t1_busy", busy, 1);
      cyc();
      chk("t1_noplot_g1", plot, 0);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("t1_pixel", {plot, x, y, colour},
             {1'b1, 8'(10 + k % 2), 8'(20 + k / 2), 12'(k + 1)});
      end
      cyc();
      chk("t1_done", done, 3'b001);
      chk("t1_done_noplot", plot, 0);
      req[0] = 1'b0;
      cyc();
      chk("t1_idle", {grant, done, busy}, 0);

      // colour key on
      rom_mode = 1;
      start(1, 8'd5, 8'd6, 8'd4, 8'd1, 1'b1);
      chk("t2_grant", grant, 3'b010);
      chk("t2_sel", rom_sel, 2'd1);
      cyc();
      cyc();
      chk("t2_k0_hold", {plot, x, y, colour}, {1'b0, 8'd11, 8'd21, 12'd4});
      cyc();
      chk("t2_k1", {plot, x, y, colour}, {1'b1, 8'd6, 8'd6, 12'hFFF});
      cyc();
      chk("t2_k2_hold", {plot, x, y, colour}, {1'b0, 8'd6, 8'd6, 12'hFFF});
      cyc();
      chk("t2_k3", {plot, x, y, colour}, {1'b1, 8'd8, 8'd6, 12'h123});
      cyc();
      chk("t2_done", done, 3'b010);
      req[1] = 1'b0;
      cyc();

      // colour key off: every pixel plots
      start(1, 8'd5, 8'd6, 8'd4, 8'd1, 1'b0);
      cyc();
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("t2b_pixel", {plot, x, colour},
             {1'b1, 8'(5 + k), rom_data(15'(k))});
      end
      cyc();
      chk("t2b_done", done, 3'b010);
      req[1] = 1'b0;
      cyc();

      // clipping at the bottom-right corner
      rom_mode = 0;
      start(2, 8'd158, 8'd119, 8'd4, 8'd2, 1'b0);
      for (int j = 0; j < 10; j++) begin
         if (j < 8) chk("t3_addr", rom_addr, 15'(j));
         if (j >= 2) chk("t3_plot", plot, (j - 2 < 2) ? 1 : 0);
         if (j == 2) chk("t3_p0", {x, y, colour}, {8'd158, 8'd119, 12'd1});
         if (j == 3) chk("t3_p1", {x, y, colour}, {8'd159, 8'd119, 12'd2});
         if (j == 9) chk("t3_hold", {x, y}, {8'd159, 8'd119});
         cyc();
      end
      chk("t3_done", done, 3'b100);
      req[2] = 1'b0;
      cyc();

      // round-robin with all requests held
      for (int i = 0; i < 3; i++) begin
         req_x0[8*i +: 8] = 8'(i * 10);
         req_y0[8*i +: 8] = 8'd0;
         req_w[8*i +: 8]  = 8'd1;
         req_h[8*i +: 8]  = 8'd1;
         req_key[i]       = 1'b0;
      end
      req = 3'b111;
      ng = 0; zrun = 0; multi = 0; prevg = '0;
      for (int c = 0; c < 40; c++) begin
         cyc();
         if ($countones(grant) > 1) multi++;
         if (grant != 0 && prevg == 0) begin
            if (ng < 4) seq[ng] = grant;
            if (ng > 0 && ng < 4) gaps[ng-1] = zrun;
            ng++;
            zrun = 0;
            if (ng == 4) req = '0;
         end
         if (grant == 0) zrun++;
         prevg = grant;
      end
      chk("rr_count", ng, 4);
      chk("rr_g0", seq[0], 3'b001);
      chk("rr_g1", seq[1], 3'b010);
      chk("rr_g2", seq[2], 3'b100);
      chk("rr_g3", seq[3], 3'b001);
      for (int g = 0; g < 3; g++) chk("rr_gap", gaps[g], 1);
      chk("rr_onehot", multi, 0);

      // degenerate rectangle
      start(0, 8'd3, 8'd3, 8'd0, 8'd3, 1'b0);
      chk("t5_grant", grant, 3'b001);
      chk("t5_noplot", plot, 0);
      cyc();
      chk("t5_done", {done, plot}, {3'b001, 1'b0});
      req[0] = 1'b0;
      cyc();
      chk("t5_idle", {grant, busy, plot}, 0);

      // abort mid-RUN, then pointer restarts at index 0
      start(1, 8'd0, 8'd0, 8'd10, 8'd10, 1'b0);
      repeat (5) cyc();
      chk("t6_plotting", {plot, x}, {1'b1, 8'd3});
      req_x0[7:0] = 8'd1;  req_y0[7:0] = 8'd1;
      req_w[7:0]  = 8'd1;  req_h[7:0]  = 8'd1;
      req_x0[23:16] = 8'd2; req_y0[23:16] = 8'd2;
      req_w[23:16]  = 8'd1; req_h[23:16]  = 8'd1;
      req = 3'b101;
      resetn = 1'b0;
      #1;
      chk("t6_async_zero",
          {grant, done, rom_addr, rom_sel, x, y, colour, plot, busy}, 0);
      cyc();
      chk("t6_held_zero", {grant, busy, plot}, 0);
      resetn = 1'b1;
      cyc();
      chk("t6_regrant0", grant, 3'b001);
      repeat (2) cyc();
      chk("t6_pix", {plot, x, y}, {1'b1, 8'd1, 8'd1});
      cyc();
      chk("t6_done0", done, 3'b001);
      req[0] = 1'b0;
      cyc();
      cyc();
      chk("t6_grant2", grant, 3'b100);
      repeat (3) cyc();
      chk("t6_done2", done, 3'b100);
      req = '0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
